// File: rtl/ram_scan_pkg.sv
// Shared definitions for the register-file scan controller: state encoding
// and the ceiling-log2 helper used to size address buses.
package ram_scan_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    SEND  = ST_SEND,
    DONE  = ST_DONE
  } state_t;

  function automatic int Log(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_scan_cnt.sv
// Address counter for the scan: clears to zero, steps by one on request and
// flags the last valid address N-1.
module scan_cnt
  import ram_scan_pkg::*;
#(
  parameter  int N = 8,
  localparam int G = Log(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [G-1:0] cnt,
  output logic         last
);

  logic [G-1:0] cnt_q;
  logic [G-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == G'(N - 1));

endmodule

// File: rtl/ram_scan.sv
// Walks the register file from address 0 to N-1, registering each word and
// offering it downstream over a valid/ready handshake.
module ram_scan
  import ram_scan_pkg::*;
#(
  parameter  int N = 8,
  parameter  int W = 4,
  localparam int G = Log(N)
) (
  input  logic         C,
  input  logic         nR,
  input  logic         Start,
  output logic [G-1:0] A,
  input  logic [W-1:0] RD,
  output logic [W-1:0] Y,
  output logic         V,
  input  logic         Rdy,
  output logic         Busy,
  output logic         Done
);

  state_t       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic         v_q, v_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         cnt_inc;
  logic         cnt_clr;
  logic         cnt_last;

  scan_cnt #(.N(N)) u_cnt (
    .clk  (C),
    .rst_n(nR),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (A),
    .last (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    done_d  = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) state_d = FETCH;
      end
      FETCH: begin
        y_d     = RD;
        v_d     = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        // The word stays put until the consumer takes it.
        if (Rdy) begin
          v_d = 1'b0;
          if (cnt_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FETCH) || (state_d == SEND);
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= IDLE;
      y_q     <= '0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y    = y_q;
  assign V    = v_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_ram_scan.sv
// Self-checking bench for ram_scan: table-driven scan scenarios on N=8 and N=5
// instances plus hand-written reset and write-during-scan sequences.
module tb_ram_scan;

  logic       C;
  logic       nR;
  logic       Start;
  logic       Rdy;
  bit         sel;

  logic [2:0] a8, a5;
  logic [3:0] y8, y5, rd8, rd5;
  logic       v8, v5, busy8, busy5, done8, done5;
  logic       start8, start5;

  logic [3:0] mem8 [8];
  logic [3:0] mem5 [5];

  assign start8 = Start & ~sel;
  assign start5 = Start & sel;

  always_comb begin
    rd8 = mem8[a8];
    rd5 = 4'h0;
    if (a5 < 3'd5) rd5 = mem5[a5];
  end

  ram_scan #(.N(8), .W(4)) dut8 (
    .C(C), .nR(nR), .Start(start8), .A(a8), .RD(rd8), .Y(y8), .V(v8),
    .Rdy(Rdy), .Busy(busy8), .Done(done8)
  );

  ram_scan #(.N(5), .W(4)) dut5 (
    .C(C), .nR(nR), .Start(start5), .A(a5), .RD(rd5), .Y(y5), .V(v5),
    .Rdy(Rdy), .Busy(busy5), .Done(done5)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed outputs of the selected instance, sampled between edges.
  int cur_a, cur_y, cur_v, cur_busy, cur_done;
  int prev_v, prev_rdy, prev_y, prev_a;
  int got_y[$];
  int got_a[$];
  int exp_w [8];
  int busy_cnt, done_cnt, done_cyc, v_cnt, max_a, cyc;

  typedef struct {
    bit         s;
    int         mode;
    logic [3:0] pat;
    int         hold;
    int         words;
    int         exp_busy;
    int         exp_done;
  } scen_t;

  scen_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    cur_a    = sel ? int'(a5) : int'(a8);
    cur_y    = sel ? int'(y5) : int'(y8);
    cur_v    = sel ? int'(v5) : int'(v8);
    cur_busy = sel ? int'(busy5) : int'(busy8);
    cur_done = sel ? int'(done5) : int'(done8);
  endtask

  task automatic observe();
    sample();
    if (prev_v == 1 && prev_rdy == 0) begin
      chk("hold_v", cur_v, 1);
      chk("hold_y", cur_y, prev_y);
      chk("hold_a", cur_a, prev_a);
    end
    if (cur_v == 1 && Rdy == 1'b1) begin
      got_y.push_back(cur_y);
      got_a.push_back(cur_a);
    end
    busy_cnt += cur_busy;
    done_cnt += cur_done;
    v_cnt    += cur_v;
    if (cur_a > max_a) max_a = cur_a;
    if (cur_done == 1 && done_cyc < 0) done_cyc = cyc;
    prev_v   = cur_v;
    prev_rdy = int'(Rdy);
    prev_y   = cur_y;
    prev_a   = cur_a;
  endtask

  task automatic cycle(input int st, input logic rdy);
    @(negedge C);
    Start = (st != 0);
    Rdy   = rdy;
    #1;
    observe();
    cyc++;
  endtask

  function automatic logic pick_rdy(input int mode, input logic [3:0] pat, input int j);
    if (mode == 1) return 1'($urandom_range(0, 1));
    return pat[j % 4];
  endfunction

  task automatic assert_reset_now(input string tag);
    nR = 1'b0;
    #1;
    sample();
    chk({tag, "_A"}, cur_a, 0);
    chk({tag, "_Y"}, cur_y, 0);
    chk({tag, "_V"}, cur_v, 0);
    chk({tag, "_Busy"}, cur_busy, 0);
    chk({tag, "_Done"}, cur_done, 0);
    @(negedge C);
    Start = 1'b0;
    nR    = 1'b1;
    prev_v = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge C);
    #1;
    assert_reset_now(tag);
  endtask

  task automatic load(input int rnd);
    for (int i = 0; i < 8; i++) mem8[i] = (rnd != 0) ? 4'($urandom_range(0, 15)) : 4'((i + 3) % 16);
    for (int i = 0; i < 5; i++) mem5[i] = (rnd != 0) ? 4'($urandom_range(0, 15)) : 4'((i + 3) % 16);
  endtask

  task automatic start_stats();
    got_y.delete();
    got_a.delete();
    busy_cnt = 0; done_cnt = 0; v_cnt = 0; max_a = 0; cyc = 0; done_cyc = -1;
    for (int i = 0; i < 8; i++) exp_w[i] = sel ? ((i < 5) ? int'(mem5[i]) : 0) : int'(mem8[i]);
  endtask

  task automatic continue_scan(input int mode, input logic [3:0] pat, input int hold, input int budget);
    while (done_cnt == 0 && cyc < budget) cycle(hold, pick_rdy(mode, pat, cyc));
    chk("scan_finished_in_budget", int'(done_cnt > 0), 1);
  endtask

  task automatic compare_scan(input int n);
    chk("n_words", got_y.size(), n);
    for (int i = 0; i < n && i < got_y.size(); i++) begin
      chk($sformatf("word%0d_y", i), got_y[i], exp_w[i]);
      chk($sformatf("word%0d_a", i), got_a[i], i);
    end
    chk("done_pulses", done_cnt, 1);
    chk("max_addr", max_a, n - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 0, 4'b1111, 0, 8, 16, 17};
    tbl[1] = '{1'b0, 0, 4'b1001, 0, 8, -1, -1};
    tbl[2] = '{1'b1, 0, 4'b1111, 0, 5, 10, 11};
    tbl[3] = '{1'b1, 1, 4'b0000, 0, 5, -1, -1};
    tbl[4] = '{1'b0, 1, 4'b0000, 0, 8, -1, -1};
    tbl[5] = '{1'b0, 0, 4'b1111, 1, 8, 16, 17};

    nR = 1'b0; Start = 1'b0; Rdy = 1'b0; sel = 1'b0;
    prev_v = 0; prev_rdy = 0; prev_y = 0; prev_a = 0;
    load(0);
    sel = 1'b0; do_reset("por8");
    sel = 1'b1; do_reset("por5");

    // Reset while word 3 is being offered: everything clears, no Done follows.
    sel = 1'b0;
    load(0);
    start_stats();
    cycle(1, 1'b1);
    while (!(cur_a == 3 && cur_v == 1) && cyc < 60) cycle(0, 1'b1);
    chk("reached_word3", cur_a, 3);
    #1;
    assert_reset_now("midrst");
    start_stats();
    for (int i = 0; i < 4; i++) cycle(0, 1'b1);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_valid", v_cnt, 0);

    for (int t = 0; t < 6; t++) begin
      sel = tbl[t].s;
      load((tbl[t].mode == 1) ? 1 : 0);
      start_stats();
      cycle(1, pick_rdy(tbl[t].mode, tbl[t].pat, 0));
      continue_scan(tbl[t].mode, tbl[t].pat, tbl[t].hold, 400);
      compare_scan(tbl[t].words);
      if (tbl[t].exp_busy >= 0) begin
        chk("busy_cycles", busy_cnt, tbl[t].exp_busy);
        chk("valid_cycles", v_cnt, tbl[t].words);
        chk("done_cycle", done_cyc, tbl[t].exp_done);
      end
      cycle(tbl[t].hold, 1'b1);
      chk("idle_A", cur_a, 0);
      chk("idle_V", cur_v, 0);
      chk("idle_Busy", cur_busy, 0);
      cycle(tbl[t].hold, 1'b1);
      chk("restart_Busy", cur_busy, tbl[t].hold);
      if (tbl[t].hold != 0) do_reset("abort");
      $display("scenario %0d: sel=%0d mode=%0d words=%0d busy=%0d done_cyc=%0d", t,
               tbl[t].s, tbl[t].mode, got_y.size(), busy_cnt, done_cyc);
    end

    // Writes during a scan: captured word 2 holds, later address 6 sees new data.
    sel = 1'b0;
    load(0);
    start_stats();
    cycle(1, 1'b1);
    while (got_y.size() < 2 && cyc < 60) cycle(0, 1'b1);
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    mem8[6] = 4'hF;
    mem8[2] = 4'h0;
    cycle(0, 1'b0);
    cycle(0, 1'b0);
    chk("wr_hold_y", cur_y, exp_w[2]);
    chk("wr_hold_a", cur_a, 2);
    chk("wr_hold_v", cur_v, 1);
    exp_w[6] = 15;
    continue_scan(0, 4'b1111, 0, cyc + 100);
    compare_scan(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
